// File: rtl/rs_cw_packer.sv
// Packs a byte stream of 256-byte RS codewords into 16 x 128-bit beats per codeword.
// A truncated codeword is zero-padded out to 16 beats so downstream beat counters stay aligned.
module rs_cw_packer (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   i_byte_in,
    input  logic         i_byte_valid,
    input  logic         i_byte_sop,
    output logic         o_byte_ready,
    output logic [127:0] o_data_out,
    output logic         o_valid_out,
    output logic [3:0]   o_beat_idx,
    output logic         o_cw_last,
    output logic         o_frame_err,
    output logic         o_pad_active
);

    localparam int unsigned BEATS_PER_CW = 16;
    localparam int unsigned LANES        = 16;
    localparam int unsigned LANE_W       = 8;
    localparam int unsigned DATA_W       = LANES * LANE_W;
    localparam int unsigned POS_W        = 8;
    localparam int unsigned IDX_W        = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_PAD  = 2'd2;

    logic [1:0]        r_state;
    logic [POS_W-1:0]  r_pos;
    logic [DATA_W-1:0] r_lanes;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid_out;
    logic [IDX_W-1:0]  r_beat_idx;
    logic              r_cw_last;
    logic              r_frame_err;
    logic              r_pad_active;
    logic              r_hold_valid;
    logic [LANE_W-1:0] r_hold_byte;
    logic              r_byte_ready;

    logic [1:0]        w_state_nxt;
    logic [POS_W-1:0]  w_pos_nxt;
    logic [DATA_W-1:0] w_lanes_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_valid_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_last_nxt;
    logic              w_ferr_nxt;
    logic              w_pad_nxt;
    logic              w_hold_valid_nxt;
    logic [LANE_W-1:0] w_hold_byte_nxt;
    logic              w_ready_nxt;
    logic              w_xfer;

    assign w_xfer = i_byte_valid & r_byte_ready;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pos        <= '0;
            r_lanes      <= '0;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_beat_idx   <= '0;
            r_cw_last    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_pad_active <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_byte  <= '0;
            r_byte_ready <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_pos        <= w_pos_nxt;
            r_lanes      <= w_lanes_nxt;
            r_data_out   <= w_data_nxt;
            r_valid_out  <= w_valid_nxt;
            r_beat_idx   <= w_idx_nxt;
            r_cw_last    <= w_last_nxt;
            r_frame_err  <= w_ferr_nxt;
            r_pad_active <= w_pad_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_hold_byte  <= w_hold_byte_nxt;
            r_byte_ready <= w_ready_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_pos_nxt        = r_pos;
        w_lanes_nxt      = r_lanes;
        w_data_nxt       = r_data_out;
        w_valid_nxt      = 1'b0;
        w_idx_nxt        = r_beat_idx;
        w_last_nxt       = 1'b0;
        w_ferr_nxt       = 1'b0;
        w_hold_valid_nxt = r_hold_valid;
        w_hold_byte_nxt  = r_hold_byte;

        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (i_byte_sop) begin
                        w_lanes_nxt = DATA_W'(i_byte_in);
                        w_pos_nxt   = POS_W'(1);
                        w_state_nxt = S_FILL;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                    end
                end
            end

            S_FILL: begin
                if (w_xfer) begin
                    if (i_byte_sop) begin
                        // Early sop: park the new byte and pad out the current codeword
                        w_hold_byte_nxt  = i_byte_in;
                        w_hold_valid_nxt = 1'b1;
                        w_ferr_nxt       = 1'b1;
                        w_state_nxt      = S_PAD;
                    end else begin
                        w_lanes_nxt[{r_pos[3:0], 3'b000} +: LANE_W] = i_byte_in;
                        w_pos_nxt = r_pos + POS_W'(1);
                        if (r_pos[3:0] == 4'hF) begin
                            w_data_nxt  = w_lanes_nxt;
                            w_valid_nxt = 1'b1;
                            w_idx_nxt   = r_pos[7:4];
                            w_last_nxt  = (r_pos[7:4] == IDX_W'(BEATS_PER_CW - 1));
                            w_lanes_nxt = '0;
                        end
                        if (r_pos == 8'hFF) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end

            S_PAD: begin
                // Unwritten lanes are already zero because the buffer clears after every beat
                w_data_nxt  = r_lanes;
                w_valid_nxt = 1'b1;
                w_idx_nxt   = r_pos[7:4];
                w_last_nxt  = (r_pos[7:4] == IDX_W'(BEATS_PER_CW - 1));
                w_lanes_nxt = '0;
                w_pos_nxt   = {r_pos[7:4] + 4'd1, 4'h0};
                if (r_pos[7:4] == IDX_W'(BEATS_PER_CW - 1)) begin
                    w_lanes_nxt      = DATA_W'(r_hold_byte);
                    w_pos_nxt        = POS_W'(1);
                    w_hold_valid_nxt = 1'b0;
                    w_state_nxt      = S_FILL;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_ready_nxt = (w_state_nxt != S_PAD) & ~w_hold_valid_nxt;
        // Covers the frame_err cycle through the final pad beat
        w_pad_nxt   = (w_state_nxt == S_PAD) | (r_state == S_PAD);
    end

    assign o_byte_ready = r_byte_ready;
    assign o_data_out   = r_data_out;
    assign o_valid_out  = r_valid_out;
    assign o_beat_idx   = r_beat_idx;
    assign o_cw_last    = r_cw_last;
    assign o_frame_err  = r_frame_err;
    assign o_pad_active = r_pad_active;

endmodule
